input_conditioner: RTL and testbench

Multi-channel successor to the single-bit synchronizer. Each channel takes an asynchronous input through an FF_COUNT-deep synchronizer, then an optional per-channel debounce filter. It also produces registered one-cycle rise/fall pulses. Used for buttons, external status pins and strap inputs entering the clk domain.

---
 rtl/input_conditioner.sv | 80 ++++++++
 tb/tb_input_conditioner.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-channel synchronizer, optional
// debounce filter and registered rise/fall/changed pulses.
module input_conditioner #(
  parameter int               WIDTH       = 4,
  parameter int               FF_COUNT    = 3,
  parameter int               DEBOUNCE    = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] debounce_en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int CNT_W =
    (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DEBOUNCE - 1);

  logic [FF_COUNT-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]               out_q, out_d;
  logic [WIDTH-1:0]               rise_q, rise_d;
  logic [WIDTH-1:0]               fall_q, fall_d;
  logic                           changed_q, changed_d;
  logic [WIDTH-1:0]               s;

  assign s = sync_q[FF_COUNT-1];

  always_comb begin
    sync_d = {sync_q[FF_COUNT-2:0], in};
    out_d  = out_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!debounce_en[i]) begin
        out_d[i] = s[i];
        cnt_d[i] = '0;
      end else if (s[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == TERM) begin
        out_d[i] = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // Pulses line up with the first cycle out shows the new level
    rise_d    = out_d & ~out_q;
    fall_d    = ~out_d & out_q;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q    <= {FF_COUNT{RESET_VALUE}};
      cnt_q     <= '0;
      out_q     <= RESET_VALUE;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign out     = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed latency/glitch/reset scenarios
// plus randomized traffic against a behavioural model.
module tb_input_conditioner;

  localparam int W  = 4;
  localparam int FF = 3;
  localparam int D  = 4;
  localparam logic [W-1:0] RV = 4'b0000;

  logic         clk;
  logic         resetn;
  logic [W-1:0] in_r;
  logic [W-1:0] en_r;
  logic [W-1:0] out_w, rise_w, fall_w;
  logic         changed_w;
  logic [W-1:0] out1_w, rise1_w, fall1_w;
  logic         changed1_w;
  logic [W-1:0] en_all;

  int n_cmp;
  int n_err;

  assign en_all = 4'b1111;

  input_conditioner #(
    .WIDTH(W), .FF_COUNT(FF), .DEBOUNCE(D),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .resetn(resetn), .in(in_r),
    .debounce_en(en_r), .out(out_w),
    .rise(rise_w), .fall(fall_w),
    .changed(changed_w)
  );

  // DEBOUNCE=1 instance, always filtered: must time like bypass
  input_conditioner #(
    .WIDTH(W), .FF_COUNT(FF), .DEBOUNCE(1),
    .RESET_VALUE(RV)
  ) dut1 (
    .clk(clk), .resetn(resetn), .in(in_r),
    .debounce_en(en_all), .out(out1_w),
    .rise(rise1_w), .fall(fall1_w),
    .changed(changed1_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: delay line of raw samples, then a
  // run-length of consecutive disagreements with the output.
  logic [W-1:0] m_pipe [FF];
  logic [W-1:0] m_out, m_rise, m_fall;
  logic         m_changed;
  int           m_run [W];
  logic [W-1:0] n_out;
  int           n_run [W];

  always_comb begin
    n_out = m_out;
    for (int i = 0; i < W; i++) begin
      n_run[i] = 0;
      if (!en_r[i]) begin
        n_out[i] = m_pipe[FF-1][i];
      end else if (m_pipe[FF-1][i] != m_out[i]) begin
        if (m_run[i] + 1 == D) n_out[i] = m_pipe[FF-1][i];
        else n_run[i] = m_run[i] + 1;
      end
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < FF; k++) m_pipe[k] <= RV;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
      m_out     <= RV;
      m_rise    <= '0;
      m_fall    <= '0;
      m_changed <= 1'b0;
    end else begin
      m_pipe[0] <= in_r;
      for (int k = 1; k < FF; k++) m_pipe[k] <= m_pipe[k-1];
      for (int i = 0; i < W; i++) m_run[i] <= n_run[i];
      m_out     <= n_out;
      m_rise    <= n_out & ~m_out;
      m_fall    <= ~n_out & m_out;
      m_changed <= (n_out != m_out);
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    en_r   = '0;
    in_r   = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_w, rise_w, fall_w, changed_w} !== 13'd0) begin
        n_err++;
        $display("FAIL reset_hold k=%0d out=%b rise=%b fall=%b chg=%b want all 0",
                 k, out_w, rise_w, fall_w, changed_w);
      end
    end
    in_r   = '0;
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_w, rise_w, fall_w, changed_w, rise1_w, fall1_w} !== 21'd0) begin
        n_err++;
        $display("FAIL reset_release k=%0d out=%b rise=%b fall=%b chg=%b want all 0",
                 k, out_w, rise_w, fall_w, changed_w);
      end
    end
  endtask

  task automatic test_bypass_latency();
    en_r = '0;
    in_r = '0;
    repeat (10) @(negedge clk);
    in_r[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_w[0] !== (k >= 4) || rise_w[0] !== (k == 4) ||
          changed_w !== (k == 4) || out1_w[0] !== (k >= 4) ||
          rise1_w[0] !== (k == 4) || changed1_w !== (k == 4)) begin
        n_err++;
        $display("FAIL bypass_rise k=%0d out=%b rise=%b chg=%b d1out=%b want out0=%0d rise0=%0d",
                 k, out_w, rise_w, changed_w, out1_w, k >= 4, k == 4);
      end
    end
    in_r[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_w[0] !== (k < 4) || fall_w[0] !== (k == 4) ||
          rise_w[0] !== 1'b0 || changed_w !== (k == 4) ||
          fall1_w[0] !== (k == 4)) begin
        n_err++;
        $display("FAIL bypass_fall k=%0d out=%b fall=%b rise=%b chg=%b want out0=%0d fall0=%0d",
                 k, out_w, fall_w, rise_w, changed_w, k < 4, k == 4);
      end
    end
  endtask

  task automatic test_filtered_latency();
    en_r = 4'b1111;
    in_r = '0;
    repeat (12) @(negedge clk);
    in_r[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_w[1] !== (k >= 7) || rise_w[1] !== (k == 7) ||
          changed_w !== (k == 7)) begin
        n_err++;
        $display("FAIL filtered_rise k=%0d out=%b rise=%b chg=%b want out1=%0d rise1=%0d",
                 k, out_w, rise_w, changed_w, k >= 7, k == 7);
      end
    end
  endtask

  task automatic test_glitch();
    en_r = 4'b1111;
    in_r = '0;
    repeat (12) @(negedge clk);
    for (int len = 3; len <= 4; len++) begin
      in_r[2] = 1'b1;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (k == len) in_r[2] = 1'b0;
        n_cmp++;
        if (len == 3 && (out_w[2] !== 1'b0 || rise_w[2] !== 1'b0)) begin
          n_err++;
          $display("FAIL glitch3 k=%0d out=%b rise=%b want out2=0 rise2=0",
                   k, out_w, rise_w);
        end
        if (len == 4 && (out_w[2] !== (k >= 7 && k < 11) ||
            rise_w[2] !== (k == 7) || fall_w[2] !== (k == 11))) begin
          n_err++;
          $display("FAIL glitch4 k=%0d out=%b rise=%b fall=%b want out2=%0d",
                   k, out_w, rise_w, fall_w, k >= 7 && k < 11);
        end
      end
    end
  endtask

  task automatic test_concurrency();
    en_r = '0;
    in_r = '0;
    repeat (10) @(negedge clk);
    in_r = 4'b1001;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rise_w !== ((k == 4) ? 4'b1001 : 4'b0000) ||
          changed_w !== (k == 4) || fall_w !== 4'b0000) begin
        n_err++;
        $display("FAIL concurrent k=%0d rise=%b fall=%b chg=%b want rise=%b",
                 k, rise_w, fall_w, changed_w,
                 (k == 4) ? 4'b1001 : 4'b0000);
      end
    end
  endtask

  task automatic test_mode_switch();
    en_r = 4'b1111;
    in_r = '0;
    repeat (12) @(negedge clk);
    in_r[1] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_w[1] !== (k >= 6) || rise_w[1] !== (k == 6) ||
          {out_w, rise_w, fall_w, changed_w} !==
          {m_out, m_rise, m_fall, m_changed}) begin
        n_err++;
        $display("FAIL mode_switch k=%0d out=%b rise=%b want out1=%0d rise1=%0d model_out=%b",
                 k, out_w, rise_w, k >= 6, k == 6, m_out);
      end
      if (k == 5) en_r[1] = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    en_r = 4'b1111;
    in_r = '0;
    repeat (12) @(negedge clk);
    in_r[1] = 1'b1;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (out_w !== 4'b0000 || m_out !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset_now out=%b model=%b want 0000",
               out_w, m_out);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_w[1] !== (k >= 7) || rise_w[1] !== (k == 7) ||
          changed_w !== (k == 7)) begin
        n_err++;
        $display("FAIL async_reset_requal k=%0d out=%b rise=%b chg=%b want out1=%0d rise1=%0d",
                 k, out_w, rise_w, changed_w, k >= 7, k == 7);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_w, rise_w, fall_w, changed_w} !==
          {m_out, m_rise, m_fall, m_changed} ||
          (rise_w & fall_w) !== 4'b0000) begin
        n_err++;
        $display("FAIL random c=%0d out=%b rise=%b fall=%b chg=%b want out=%b rise=%b fall=%b chg=%b",
                 c, out_w, rise_w, fall_w, changed_w,
                 m_out, m_rise, m_fall, m_changed);
      end
      for (int i = 0; i < W; i++)
        if ($urandom_range(4, 0) == 0) in_r[i] = ~in_r[i];
      if ($urandom_range(39, 0) == 0) en_r = 4'($urandom);
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(149, 0) == 0) resetn = 1'b0;
    end
    resetn = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_bypass_latency();
    test_filtered_latency();
    test_glitch();
    test_concurrency();
    test_mode_switch();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
